// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encodings and small op-decode helpers used by md_unit and md_core.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MADD  = 4'd4,
    MD_MADDU = 4'd5,
    MD_MSUB  = 4'd6,
    MD_MSUBU = 4'd7,
    MD_MTHI  = 4'd8,
    MD_MTLO  = 4'd9
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  // Ops 0..7 run through the iterative datapath.
  function automatic logic md_iter(input logic [3:0] op);
    return ~op[3];
  endfunction

  function automatic logic md_div(input logic [3:0] op);
    return op[3:1] == 3'b001;
  endfunction

  // Among the iterative ops, even codes are the signed variants.
  function automatic logic md_signed(input logic [3:0] op);
    return ~op[3] & ~op[0];
  endfunction

endpackage

// File: rtl/md_core.sv
// Iterative datapath: shift-add multiply / restoring divide over WIDTH-bit
// magnitudes, iteration counter and final sign correction.
//   load  : latch operands (magnitudes), signs and mode; clear counter
//   step  : perform one iteration
//   last  : the current step is the final one
//   res   : sign-corrected result, {hi,lo} = product or {remainder,quotient}
module md_core
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               step,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH);

  // Mult: hi_q = running upper half, lo_q = multiplier shifting out, m_q = multiplicand.
  // Div:  hi_q = partial remainder, lo_q = dividend shifting into quotient, m_q = divisor.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sa_q, sa_d, sb_q, sb_d, sgn_q, sgn_d, div_q, div_d, dz_q, dz_d;

  logic [WIDTH:0]   sum, r_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign mag_a = (md_signed(op) && a[WIDTH-1]) ? -a : a;
  assign mag_b = (md_signed(op) && b[WIDTH-1]) ? -b : b;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    sgn_d = sgn_q;
    div_d = div_q;
    dz_d  = dz_q;
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    r_sh  = {hi_q, lo_q[WIDTH-1]};
    diff  = {1'b0, r_sh} - {2'b00, m_q};
    if (load) begin
      sgn_d = md_signed(op);
      div_d = md_div(op);
      sa_d  = md_signed(op) & a[WIDTH-1];
      sb_d  = md_signed(op) & b[WIDTH-1];
      dz_d  = md_div(op) && (b == '0);
      cnt_d = '0;
      if (md_div(op) && (b == '0)) begin
        // Divide by zero bypasses iteration: result is preset here.
        hi_d = a;
        lo_d = '1;
        m_d  = '0;
      end else if (md_div(op)) begin
        hi_d = '0;
        lo_d = mag_a;
        m_d  = mag_b;
      end else begin
        hi_d = '0;
        lo_d = mag_b;
        m_d  = mag_a;
      end
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        // Restoring step: keep the subtraction only if it did not borrow.
        if (!diff[WIDTH+1]) hi_d = diff[WIDTH-1:0];
        else                hi_d = r_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH+1]};
      end else begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      sgn_q <= 1'b0;
      div_q <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      sgn_q <= sgn_d;
      div_q <= div_d;
      dz_q  <= dz_d;
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

  // MIN / -1 needs no special case: magnitude quotient MIN negates to MIN.
  always_comb begin
    res = {hi_q, lo_q};
    if (dz_q) begin
      res = {hi_q, lo_q};
    end else if (div_q) begin
      res[WIDTH-1:0]       = (sgn_q && (sa_q ^ sb_q)) ? -lo_q : lo_q;
      res[2*WIDTH-1:WIDTH] = (sgn_q && sa_q) ? -hi_q : hi_q;
    end else if (sgn_q && (sa_q ^ sb_q)) begin
      res = -{hi_q, lo_q};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: accept handshake, IDLE/CALC/FIX
// FSM, HI/LO registers and the multiply-accumulate adder around md_core.
//   start/op/a/b : operation request (accepted when idle, not done, not annulled)
//   annul        : drop any in-flight operation, HI/LO untouched
//   busy/done    : registered status; done pulses the cycle after HI/LO update
//   stallreq     : combinational stall request for the pipeline
//   hi/lo        : architectural HI/LO
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             busy,
  output logic             done,
  output logic             stallreq,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  md_state_e        state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [3:0]       op_q, op_d;
  logic             accept, load, step, last;
  logic [2*WIDTH-1:0] res;

  // done blocks acceptance so a stalled EX instruction cannot re-issue.
  assign accept = start & ~busy_q & ~done_q & ~annul;

  md_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .resetn (resetn),
    .load   (load),
    .step   (step),
    .op     (op),
    .a      (a),
    .b      (b),
    .last   (last),
    .res    (res)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (md_iter(op)) begin
            load    = 1'b1;
            op_d    = op;
            state_d = (md_div(op) && (b == '0)) ? S_FIX : S_CALC;
          end else if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_CALC: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          step = 1'b1;
          if (last) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!annul) begin
          // op[2] selects accumulate; within those, op[1] selects subtract.
          if (!op_q[2])     {hi_d, lo_d} = res;
          else if (op_q[1]) {hi_d, lo_d} = {hi_q, lo_q} - res;
          else              {hi_d, lo_d} = {hi_q, lo_q} + res;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
    end
  end

  assign stallreq = resetn & (busy_q | (start & md_iter(op) & ~done_q & ~annul));
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start, annul;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stallreq;
  logic [31:0] hi, lo;

  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic        annul8;
  logic        busy8, done8, stall8;
  logic [7:0]  hi8, lo8;

  int errs = 0, checks = 0;
  logic [31:0] mhi = '0, mlo = '0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .annul(annul), .busy(busy), .done(done), .stallreq(stallreq), .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .op(op8), .a(a8), .b(b8),
    .annul(annul8), .busy(busy8), .done(done8), .stallreq(stall8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural model of one iterative op: returns new {hi,lo}.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] hl);
    longint sx, sy, ux, uy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      4'd0: return 64'(sx * sy);
      4'd1: return 64'(ux * uy);
      4'd4: return hl + 64'(sx * sy);
      4'd5: return hl + 64'(ux * uy);
      4'd6: return hl - 64'(sx * sy);
      4'd7: return hl - 64'(ux * uy);
      4'd2, 4'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (o == 4'd2) begin q = sx / sy; r = sx % sy; end
        else           begin q = ux / uy; r = ux % uy; end
        return {r[31:0], q[31:0]};
      end
      default: return hl;
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue an iterative op, count edges until done and cycles with stallreq.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit hold, output int edges, output int stalls);
    logic [63:0] exp;
    exp = model(o, x, y, {mhi, mlo});
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    #1;
    edges = 0; stalls = 0;
    if (stallreq) stalls++;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      edges++;
      #1 if (!hold) start = 1'b0;
      @(negedge clk);
      if (done) break;
      if (stallreq) stalls++;
    end
    if (!done) chk("timeout", 64'(done), 64'd1);
    chk("done_stall", 64'(stallreq), 64'd0);
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("no_reissue", 64'(busy), 64'd0);
    {mhi, mlo} = exp;
  endtask

  // MTHI/MTLO/NOP: single cycle, never busy, never done.
  task automatic run_single(input logic [3:0] o, input logic [31:0] x);
    @(negedge clk);
    op = o; a = x; b = $urandom; start = 1'b1;
    #1 chk("single_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("single_busy", 64'(busy), 64'd0);
    chk("single_done", 64'(done), 64'd0);
    if (o == 4'd8) mhi = x;
    if (o == 4'd9) mlo = x;
  endtask

  task automatic chk_hilo(input string tag);
    chk({tag, "_hi"}, 64'(hi), 64'(mhi));
    chk({tag, "_lo"}, 64'(lo), 64'(mlo));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, s, seen;
    logic [3:0] ro;
    resetn = 1'b0; start = 1'b0; annul = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; annul8 = 1'b0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stallreq), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk) resetn = 1'b1;

    // MULT -3 * 7
    run_op(4'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, e, s);
    chk("mult_edges", 64'(e), 64'd34);
    chk("mult_stalls", 64'(s), 64'd34);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(4'd3, 32'd100, 32'd7, 1'b0, e, s);
    chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, e, s);
    chk("div_neg_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, e, s);
    chk("div_min_hilo", {hi, lo}, {32'h0, 32'h8000_0000});

    run_op(4'd3, 32'h1234, 32'd0, 1'b0, e, s);
    chk("dz_edges", 64'(e), 64'd2);
    chk("dz_stalls", 64'(s), 64'd2);
    chk("dz_hilo", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});

    run_single(4'd9, 32'd5);
    run_single(4'd8, 32'd0);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd2, 1'b0, e, s);
    chk("maddu_hilo", {hi, lo}, {32'd2, 32'd3});
    run_single(4'd8, 32'd0);
    run_single(4'd9, 32'd0);
    run_op(4'd6, 32'd1, 32'd1, 1'b0, e, s);
    chk("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

    // annul at cycle 10 of a DIV
    @(negedge clk);
    op = 4'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    @(negedge clk);
    chk("annul_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen++; end
    chk("annul_nodone", 64'(seen), 64'd0);
    chk_hilo("annul");

    // start + annul together: nothing accepted
    @(negedge clk);
    op = 4'd0; a = 32'd9; b = 32'd9; start = 1'b1; annul = 1'b1;
    #1 chk("sa_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1 op = 4'd8;
    @(posedge clk);
    #1 begin start = 1'b0; annul = 1'b0; end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen++; end
    chk("sa_none", 64'(seen), 64'd0);
    chk_hilo("sa");

    // randomized ops against the model
    for (int n = 0; n < 40; n++) begin
      ro = 4'($urandom_range(0, 15));
      if (ro < 4'd8) run_op(ro, rnd32(), rnd32(), 1'($urandom_range(0, 1)), e, s);
      else           run_single(ro, rnd32());
      chk_hilo($sformatf("rnd%0d_op%0d", n, ro));
    end

    // reset in the middle of a MULT
    run_single(4'd8, 32'h55);
    @(negedge clk);
    op = 4'd0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    start = 1'b1;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_stall", 64'(stallreq), 64'd0);
    chk("mr_hilo", {hi, lo}, 64'd0);
    start = 1'b0;
    mhi = '0; mlo = '0;
    @(negedge clk) resetn = 1'b1;

    // WIDTH=8 instance: MULT 0x80 * 0x80
    @(negedge clk);
    op8 = 4'd0; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    e = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      e++;
      #1 start8 = 1'b0;
      @(negedge clk);
      if (done8) break;
    end
    chk("w8_edges", 64'(e), 64'd10);
    chk("w8_hilo", {48'd0, hi8, lo8}, 64'h4000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
